boot_loader: RTL and testbench

BOOT_LOADER -- requirements
Module: boot_loader

---
 rtl/boot_loader.sv | 98 +++++++++
 tb/tb_boot_loader.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/boot_loader.sv
// boot_loader: streams a length-prefixed big-endian program into instruction memory, holding the CPU in reset until done
// Ports: clk, reset (async, active-high); rx_data/rx_valid/rx_ready byte input;
// imem_we/imem_addr/imem_wdata word write port; cpu_reset, done, error status.
// Optional feature macro: BOOT_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte (CHK state).
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        error
);
`ifdef BOOT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CHK, DONE, ERROR} state_t;
  localparam state_t S_END = CHK;
  logic [7:0] r_chk;
`else
  typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, DONE, ERROR} state_t;
  localparam state_t S_END = DONE;
`endif
  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_word;
  logic [1:0]  r_byte;
  logic [23:0] r_shift;
  logic        w_acc;
  logic [15:0] w_n;
  assign w_acc = rx_valid & rx_ready;
  assign w_n   = {r_len[15:8], rx_data};
`ifdef BOOT_LOADER_CHECKSUM_EN
  assign rx_ready = r_state == LEN_HI || r_state == LEN_LO || r_state == DATA || r_state == CHK;
`else
  assign rx_ready = r_state == LEN_HI || r_state == LEN_LO || r_state == DATA;
`endif
  assign cpu_reset = r_state != DONE;
  assign done      = r_state == DONE;
  assign error     = r_state == ERROR;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_len      <= '0;
      r_word     <= '0;
      r_byte     <= '0;
      r_shift    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
`ifdef BOOT_LOADER_CHECKSUM_EN
      r_chk      <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (r_state)
        IDLE: r_state <= LEN_HI;
        LEN_HI: if (w_acc) begin
          r_len[15:8] <= rx_data;
          r_state     <= LEN_LO;
        end
        LEN_LO: if (w_acc) begin
          r_len[7:0] <= rx_data;
          if (w_n == 16'd0) r_state <= S_END;
          else if (32'(w_n) > MAX_WORDS) r_state <= ERROR;
          else r_state <= DATA;
        end
        DATA: if (w_acc) begin
          r_byte  <= r_byte + 2'd1;
          r_shift <= {r_shift[15:0], rx_data};
`ifdef BOOT_LOADER_CHECKSUM_EN
          r_chk   <= r_chk ^ rx_data;
`endif
          if (r_byte == 2'd3) begin
            // word k lands at BASE_ADDR + 4k; the 32-bit add wraps naturally
            imem_we    <= 1'b1;
            imem_addr  <= BASE_ADDR + {14'd0, r_word, 2'd0};
            imem_wdata <= {r_shift, rx_data};
            r_word     <= r_word + 16'd1;
            if (r_word == r_len - 16'd1) r_state <= S_END;
          end
        end
`ifdef BOOT_LOADER_CHECKSUM_EN
        CHK: if (w_acc) begin
          if (rx_data == r_chk) r_state <= DONE;
          else r_state <= ERROR;
        end
`endif
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: directed table-driven checks of boot_loader load sequences
module tb_boot_loader;
  logic        clk, reset, rx_valid, rx_ready, imem_we, cpu_reset, done, error;
  logic [7:0]  rx_data;
  logic [31:0] imem_addr, imem_wdata;
  int tests = 0, fails = 0;
  int wr_n = 0;
  logic [31:0] wa [256];
  logic [31:0] wd [256];
  typedef struct packed {
    logic [95:0] bytes;
    logic [3:0]  n;
    logic [1:0]  gap;
    logic [1:0]  nwr;
    logic [31:0] a0, d0, a1, d1;
    logic        done_e, err_e;
  } vec_t;
  vec_t v [6];
  vec_t e;
  int nv, base;

  boot_loader dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (imem_we) begin
      wa[wr_n % 256] = imem_addr;
      wd[wr_n % 256] = imem_wdata;
      wr_n = wr_n + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1;
    #1;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    rx_data = b;
    rx_valid = 1;
    while (!rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 0, 1);
    @(negedge clk);
    rx_valid = 0;
  endtask

  initial begin
    clk = 0; reset = 1; rx_valid = 0; rx_data = 0;
`ifdef BOOT_LOADER_CHECKSUM_EN
    nv = 6;
    v[0] = '{bytes: {88'h0002_2008_0005_AC08_0000_89, 8'h0}, n: 11, gap: 0, nwr: 2,
             a0: 32'h0, d0: 32'h2008_0005, a1: 32'h4, d1: 32'hAC08_0000, done_e: 1, err_e: 0};
    v[3] = '{bytes: 96'h0, n: 3, gap: 0, nwr: 0, a0: 0, d0: 0, a1: 0, d1: 0, done_e: 1, err_e: 0};
    v[4] = '{bytes: {56'h0001_1122_3344_45, 40'h0}, n: 7, gap: 0, nwr: 1,
             a0: 32'h0, d0: 32'h1122_3344, a1: 0, d1: 0, done_e: 0, err_e: 1};
    v[5] = '{bytes: {56'h0001_1122_3344_44, 40'h0}, n: 7, gap: 1, nwr: 1,
             a0: 32'h0, d0: 32'h1122_3344, a1: 0, d1: 0, done_e: 1, err_e: 0};
`else
    nv = 4;
    v[0] = '{bytes: {80'h0002_2008_0005_AC08_0000, 16'h0}, n: 10, gap: 0, nwr: 2,
             a0: 32'h0, d0: 32'h2008_0005, a1: 32'h4, d1: 32'hAC08_0000, done_e: 1, err_e: 0};
    v[3] = '{bytes: 96'h0, n: 2, gap: 0, nwr: 0, a0: 0, d0: 0, a1: 0, d1: 0, done_e: 1, err_e: 0};
`endif
    v[1] = v[0];
    v[1].gap = 3;
    v[2] = '{bytes: {16'h0101, 80'h0}, n: 2, gap: 0, nwr: 0, a0: 0, d0: 0, a1: 0, d1: 0, done_e: 0, err_e: 1};
    repeat (2) @(negedge clk);
    reset = 0;
    for (int i = 0; i < nv; i++) begin
      e = v[i];
      do_reset();
      base = wr_n;
      for (int j = 0; j < int'(e.n); j++) begin
        send(e.bytes[95 - 8*j -: 8]);
        repeat (int'(e.gap)) @(negedge clk);
      end
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_done", i), done, e.done_e);
      chk($sformatf("v%0d_error", i), error, e.err_e);
      chk($sformatf("v%0d_cpu_reset", i), cpu_reset, !e.done_e);
      chk($sformatf("v%0d_rx_ready", i), rx_ready, 0);
      chk($sformatf("v%0d_nwr", i), wr_n - base, e.nwr);
      if (e.nwr > 0) begin
        chk($sformatf("v%0d_a0", i), wa[base % 256], e.a0);
        chk($sformatf("v%0d_d0", i), wd[base % 256], e.d0);
      end
      if (e.nwr > 1) begin
        chk($sformatf("v%0d_a1", i), wa[(base + 1) % 256], e.a1);
        chk($sformatf("v%0d_d1", i), wd[(base + 1) % 256], e.d1);
      end
      rx_valid = 1;
      rx_data = 8'h5A;
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d_term_rx_ready", i), rx_ready, 0);
      chk($sformatf("v%0d_term_done", i), done, e.done_e);
      chk($sformatf("v%0d_term_error", i), error, e.err_e);
      chk($sformatf("v%0d_term_nwr", i), wr_n - base, e.nwr);
      rx_valid = 0;
    end
    // reset in the middle of the second word, then a clean one-word load
    do_reset();
    base = wr_n;
    send(8'h00); send(8'h02);
    send(8'h01); send(8'h02); send(8'h03); send(8'h04); send(8'h05); send(8'h06);
    @(negedge clk);
    chk("abort_pre_nwr", wr_n - base, 1);
    chk("abort_pre_d0", wd[base % 256], 32'h0102_0304);
    do_reset();
    base = wr_n;
    send(8'h00); send(8'h01);
    send(8'hCA); send(8'hFE); send(8'hBA); send(8'hBE);
`ifdef BOOT_LOADER_CHECKSUM_EN
    send(8'h30);
`endif
    repeat (2) @(negedge clk);
    chk("abort_nwr", wr_n - base, 1);
    chk("abort_a0", wa[base % 256], 32'h0);
    chk("abort_d0", wd[base % 256], 32'hCAFE_BABE);
    chk("abort_done", done, 1);
    chk("abort_cpu_reset", cpu_reset, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
